// File: rtl/spi_data_path_pkg.sv
// Shared defaults and the bit-order standardise function for the SPI data path.
package spi_data_path_pkg;

  localparam int unsigned SPI_DATA_WIDTH = 32;
  localparam int unsigned SPI_FIFO_DEPTH = 8;
  localparam int unsigned SPI_MAX_WIDTH  = 32;
  localparam int unsigned SPI_IDX_W      = $clog2(SPI_MAX_WIDTH);
  localparam int unsigned SPI_LEN_W      = SPI_IDX_W + 1;

  // Map a frame of len bits so that bit len-1 goes out first; bits at or above len are zeroed.
  function automatic logic [SPI_MAX_WIDTH-1:0] bit_standardise(
    input logic [SPI_MAX_WIDTH-1:0] d,
    input logic                     dord,
    input logic [SPI_LEN_W-1:0]     len
  );
    logic [SPI_MAX_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < SPI_MAX_WIDTH; i++) begin
      if (i < 32'(len)) begin
        r[SPI_IDX_W'(i)] = dord ? d[SPI_IDX_W'(i)]
                                : d[SPI_IDX_W'(32'(len) - 32'd1 - i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_data_path_if.sv
// Bus/shifter-side signal bundle of the SPI data path; master drives, slave is the data path.
interface spi_data_path_if import spi_data_path_pkg::*; #(
  parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = SPI_FIFO_DEPTH
);
  localparam int unsigned LEN_W = $clog2(DATA_WIDTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  dord;
  logic [LEN_W-1:0]      datalen;
  logic                  tx_wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  tx_ren;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  rx_wen;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_ren;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  tx_clear;
  logic                  rx_clear;
  logic [CNT_W-1:0]      tx_thr;
  logic [CNT_W-1:0]      rx_thr;
  logic [CNT_W-1:0]      tx_count;
  logic [CNT_W-1:0]      rx_count;
  logic                  tx_full;
  logic                  tx_empty;
  logic                  rx_full;
  logic                  rx_empty;
  logic                  tx_thr_irq;
  logic                  rx_thr_irq;
  logic                  tx_ovf;
  logic                  tx_udf;
  logic                  rx_ovf;
  logic                  rx_udf;
  logic                  err_clr;

  modport master (
    output dord, datalen, tx_wen, wdata, tx_ren, rx_wen, rx_data, rx_ren,
           tx_clear, rx_clear, tx_thr, rx_thr, err_clr,
    input  tx_data, rdata, tx_count, rx_count, tx_full, tx_empty, rx_full, rx_empty,
           tx_thr_irq, rx_thr_irq, tx_ovf, tx_udf, rx_ovf, rx_udf
  );

  modport slave (
    input  dord, datalen, tx_wen, wdata, tx_ren, rx_wen, rx_data, rx_ren,
           tx_clear, rx_clear, tx_thr, rx_thr, err_clr,
    output tx_data, rdata, tx_count, rx_count, tx_full, tx_empty, rx_full, rx_empty,
           tx_thr_irq, rx_thr_irq, tx_ovf, tx_udf, rx_ovf, rx_udf
  );

endinterface

// File: rtl/spi_data_fifo.sv
// First-word-fall-through FIFO with occupancy count and sticky overflow/underflow flags.
// Error flags are live only when SPI_DATA_ERR_EN is defined; otherwise tied low.
module spi_data_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  input  logic             err_clr,
  output logic [WIDTH-1:0] head_c,
  output logic [CNT_W-1:0] count,
  output logic             full_c,
  output logic             empty_c,
  output logic             ovf,
  output logic             udf
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_c;
  logic             pop_c;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];

  // A full FIFO still takes a push when the same cycle frees a slot.
  assign pop_c  = ren && !empty_c;
  assign push_c = wen && (!full_c || pop_c);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SPI_DATA_ERR_EN
  // Setting an error wins over err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (!clear && wen && !push_c) begin
        ovf <= 1'b1;
      end else if (clear || err_clr) begin
        ovf <= 1'b0;
      end
      if (!clear && ren && empty_c) begin
        udf <= 1'b1;
      end else if (clear || err_clr) begin
        udf <= 1'b0;
      end
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: rtl/spi_data_path.sv
// SPI data path: bit-order standardising TX/RX FIFOs with threshold interrupts.
// Optional sticky FIFO error flags are enabled by defining SPI_DATA_ERR_EN.
module spi_data_path import spi_data_path_pkg::*; #(
  parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = SPI_FIFO_DEPTH
) (
  input logic           clk,
  input logic           rst_n,
  spi_data_path_if.slave bus
);

  logic [SPI_LEN_W-1:0]  frame_len_c;
  logic [DATA_WIDTH-1:0] tx_std_c;
  logic [DATA_WIDTH-1:0] rx_head_c;

  // TX is mapped once on the way in; RX head is mapped live with the current settings.
  assign frame_len_c = SPI_LEN_W'(bus.datalen) + SPI_LEN_W'(1);
  assign tx_std_c    = DATA_WIDTH'(bit_standardise(SPI_MAX_WIDTH'(bus.wdata), bus.dord, frame_len_c));
  assign bus.rdata   = DATA_WIDTH'(bit_standardise(SPI_MAX_WIDTH'(rx_head_c), bus.dord, frame_len_c));

  assign bus.tx_thr_irq = (bus.tx_count <= bus.tx_thr);
  assign bus.rx_thr_irq = (bus.rx_thr != '0) && (bus.rx_count >= bus.rx_thr);

  spi_data_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.tx_clear),
    .wen     (bus.tx_wen),
    .wdata   (tx_std_c),
    .ren     (bus.tx_ren),
    .err_clr (bus.err_clr),
    .head_c  (bus.tx_data),
    .count   (bus.tx_count),
    .full_c  (bus.tx_full),
    .empty_c (bus.tx_empty),
    .ovf     (bus.tx_ovf),
    .udf     (bus.tx_udf)
  );

  spi_data_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.rx_clear),
    .wen     (bus.rx_wen),
    .wdata   (bus.rx_data),
    .ren     (bus.rx_ren),
    .err_clr (bus.err_clr),
    .head_c  (rx_head_c),
    .count   (bus.rx_count),
    .full_c  (bus.rx_full),
    .empty_c (bus.rx_empty),
    .ovf     (bus.rx_ovf),
    .udf     (bus.rx_udf)
  );

endmodule

// File: tb/tb_spi_data_path.sv
// Scoreboard bench for spi_data_path: directed pushes queue expected words, a monitor checks pops.
module tb_spi_data_path;
  import spi_data_path_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned FD = 8;
`ifdef SPI_DATA_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_data_path_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) b ();

  spi_data_path #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] txq[$];
  logic [DW-1:0] rxq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must present the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && !b.tx_clear && b.tx_ren && !b.tx_empty) begin
      if (txq.size() == 0) chk("tx_pop_unexpected", b.tx_data, 32'hxxxx_xxxx);
      else chk("tx_pop_data", b.tx_data, txq.pop_front());
    end
    if (rst_n && !b.rx_clear && b.rx_ren && !b.rx_empty) begin
      if (rxq.size() == 0) chk("rx_pop_unexpected", b.rdata, 32'hxxxx_xxxx);
      else chk("rx_pop_data", b.rdata, rxq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_push(input logic [31:0] d, input logic [31:0] exp, input bit acc);
    b.wdata = d;
    b.tx_wen = 1'b1;
    if (acc) txq.push_back(exp);
    tick();
    b.tx_wen = 1'b0;
  endtask

  task automatic rx_push(input logic [31:0] d, input logic [31:0] exp, input bit acc);
    b.rx_data = d;
    b.rx_wen = 1'b1;
    if (acc) rxq.push_back(exp);
    tick();
    b.rx_wen = 1'b0;
  endtask

  task automatic tx_pop();
    b.tx_ren = 1'b1;
    tick();
    b.tx_ren = 1'b0;
  endtask

  task automatic rx_pop();
    b.rx_ren = 1'b1;
    tick();
    b.rx_ren = 1'b0;
  endtask

  task automatic pulse_err_clr();
    b.err_clr = 1'b1;
    tick();
    b.err_clr = 1'b0;
  endtask

  initial begin
    b.dord = 1'b1;     b.datalen = 5'd31;
    b.tx_wen = 1'b0;   b.wdata = '0;    b.tx_ren = 1'b0;
    b.rx_wen = 1'b0;   b.rx_data = '0;  b.rx_ren = 1'b0;
    b.tx_clear = 1'b0; b.rx_clear = 1'b0;
    b.tx_thr = 4'd2;   b.rx_thr = 4'd4; b.err_clr = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_tx_empty", b.tx_empty, 1);
    chk("rst_rx_empty", b.rx_empty, 1);
    chk("rst_tx_count", b.tx_count, 0);
    chk("rst_rx_count", b.rx_count, 0);
    chk("rst_tx_data", b.tx_data, 0);
    chk("rst_rdata", b.rdata, 0);
    chk("rst_tx_irq", b.tx_thr_irq, 1);
    chk("rst_rx_irq", b.rx_thr_irq, 0);
    chk("rst_tx_ovf", b.tx_ovf, 0);
    chk("rst_rx_udf", b.rx_udf, 0);
    rst_n = 1'b1;

    // LSB-first 8-bit TX mapping
    b.dord = 1'b0; b.datalen = 5'd7;
    tx_push(32'h0000_00B1, 32'h0000_008D, 1);
    chk("tx_lsb_data", b.tx_data, 32'h0000_008D);
    chk("tx_lsb_count", b.tx_count, 1);
    chk("tx_lsb_empty", b.tx_empty, 0);
    b.dord = 1'b1;
    #1 chk("tx_no_remap", b.tx_data, 32'h0000_008D);
    tx_pop();
    chk("tx_after_pop_count", b.tx_count, 0);

    // RX mapping on read follows live dord/datalen
    b.dord = 1'b0; b.datalen = 5'd11;
    rx_push(32'h0000_0ABC, 32'h0000_0ABC, 1);
    chk("rx_lsb12", b.rdata, 32'h0000_03D5);
    b.dord = 1'b1;
    #1 chk("rx_msb12", b.rdata, 32'h0000_0ABC);
    b.datalen = 5'd7;
    #1 chk("rx_msb8_trunc", b.rdata, 32'h0000_00BC);
    b.datalen = 5'd31;
    rx_pop();

    // Fill TX, overflow on the ninth push
    for (int i = 0; i < 8; i++) tx_push(32'hA000_0000 + i, 32'hA000_0000 + i, 1);
    chk("tx_full_before_ovf", b.tx_full, 1);
    tx_push(32'hDEAD_BEEF, 0, 0);
    chk("tx_full", b.tx_full, 1);
    chk("tx_full_count", b.tx_count, 8);
    chk("tx_ovf", b.tx_ovf, ERR);
    chk("tx_head_kept", b.tx_data, 32'hA000_0000);
    chk("tx_irq_full", b.tx_thr_irq, 0);
    pulse_err_clr();
    chk("tx_ovf_cleared", b.tx_ovf, 0);

    // Push+pop while full keeps count and order
    for (int i = 0; i < 8; i++) begin
      b.wdata = 32'hB000_0000 + i;
      b.tx_wen = 1'b1;
      b.tx_ren = 1'b1;
      txq.push_back(32'hB000_0000 + i);
      tick();
      b.tx_wen = 1'b0;
      b.tx_ren = 1'b0;
      chk("tx_pushpop_count", b.tx_count, 8);
    end
    for (int i = 0; i < 8; i++) tx_pop();
    chk("tx_drain_empty", b.tx_empty, 1);
    chk("tx_drain_count", b.tx_count, 0);
    chk("tx_drain_irq", b.tx_thr_irq, 1);
    tx_pop();
    chk("tx_udf", b.tx_udf, ERR);
    chk("tx_udf_count", b.tx_count, 0);

    // Clear wins over a same-cycle push and clears own flags
    for (int i = 0; i < 3; i++) tx_push(32'hC000_0000 + i, 0, 0);
    b.tx_clear = 1'b1; b.tx_wen = 1'b1; b.wdata = 32'h1234_5678;
    tick();
    b.tx_clear = 1'b0; b.tx_wen = 1'b0;
    chk("tx_clear_count", b.tx_count, 0);
    chk("tx_clear_empty", b.tx_empty, 1);
    chk("tx_clear_udf", b.tx_udf, 0);

    // RX threshold interrupt
    for (int i = 0; i < 3; i++) rx_push(32'hD000_0000 + i, 32'hD000_0000 + i, 1);
    chk("rx_irq_below", b.rx_thr_irq, 0);
    chk("rx_count3", b.rx_count, 3);
    rx_push(32'hD000_0003, 32'hD000_0003, 1);
    chk("rx_irq_at", b.rx_thr_irq, 1);
    chk("rx_count4", b.rx_count, 4);
    b.rx_thr = 4'd5;
    #1 chk("rx_irq_thr5", b.rx_thr_irq, 0);
    b.rx_thr = 4'd0;
    #1 chk("rx_irq_thr0", b.rx_thr_irq, 0);
    b.rx_thr = 4'd4;
    for (int i = 0; i < 4; i++) rx_pop();
    chk("rx_drained", b.rx_count, 0);
    chk("rx_irq_drained", b.rx_thr_irq, 0);
    rx_pop();
    chk("rx_udf", b.rx_udf, ERR);
    chk("rx_udf_count", b.rx_count, 0);
    pulse_err_clr();
    chk("rx_udf_cleared", b.rx_udf, 0);

    // Push+pop on empty: only the push lands
    b.rx_data = 32'hE000_0001; b.rx_wen = 1'b1; b.rx_ren = 1'b1;
    rxq.push_back(32'hE000_0001);
    tick();
    b.rx_wen = 1'b0; b.rx_ren = 1'b0;
    chk("rx_empty_pushpop_count", b.rx_count, 1);
    chk("rx_empty_pushpop_udf", b.rx_udf, ERR);
    rx_pop();

    // Reset mid-operation discards contents and flags
    rx_pop();
    for (int i = 0; i < 5; i++) tx_push(32'hF000_0000 + i, 0, 0);
    for (int i = 0; i < 3; i++) rx_push(32'hF100_0000 + i, 0, 0);
    chk("pre_rst_tx_count", b.tx_count, 5);
    chk("pre_rst_rx_count", b.rx_count, 3);
    chk("pre_rst_rx_udf", b.rx_udf, ERR);
    rst_n = 1'b0; b.tx_wen = 1'b1; b.wdata = 32'h5555_5555;
    tick();
    rst_n = 1'b1; b.tx_wen = 1'b0;
    chk("mid_rst_tx_count", b.tx_count, 0);
    chk("mid_rst_rx_count", b.rx_count, 0);
    chk("mid_rst_tx_empty", b.tx_empty, 1);
    chk("mid_rst_rx_empty", b.rx_empty, 1);
    chk("mid_rst_rx_udf", b.rx_udf, 0);
    chk("mid_rst_tx_data", b.tx_data, 0);
    chk("mid_rst_rdata", b.rdata, 0);

    tick();
    chk("txq_leftover", txq.size(), 0);
    chk("rxq_leftover", rxq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
